// File: rtl/indptr_fifo_p.sv
// indptr_fifo_p: parametrised CSR indptr FIFO with level flags and sticky errors.
// Define SHOWAHEAD_EN for first-word-fall-through q; the default build has a 1-cycle registered read.
module indptr_fifo_p #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = 240,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);
    localparam int UW = ADDR_WIDTH + 1;
    localparam logic [UW-1:0] FULL_LV = UW'(DEPTH);
    localparam logic [UW-1:0] AF_LV   = UW'(AF_LEVEL);
    localparam logic [UW-1:0] AE_LV   = UW'(AE_LEVEL);

    if (ADDR_WIDTH != $clog2(DEPTH) || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk
        $error("indptr_fifo_p: DEPTH must be a power of 2 >= 4 and ADDR_WIDTH == log2(DEPTH)");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]         usedw_q, usedw_d, remain;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  full_q, empty_q, af_q, ae_q, ovf_q, ovf_d, unf_q, unf_d, wr_ok, rd_ok;

    // next state: acceptance, occupancy, pointers, read data and sticky errors; sclr forces cleared values
    always_comb begin
        rd_ok    = rdreq & ~empty_q & ~sclr;
        wr_ok    = wrreq & (~full_q | rd_ok) & ~sclr;
        remain   = usedw_q - UW'(rd_ok);
        usedw_d  = sclr ? '0 : remain + UW'(wr_ok);
        wr_ptr_d = sclr ? '0 : wr_ptr_q + ADDR_WIDTH'(wr_ok);
        rd_ptr_d = sclr ? '0 : rd_ptr_q + ADDR_WIDTH'(rd_ok);
        ovf_d    = ~sclr & (ovf_q | (wrreq & full_q & ~rd_ok));
        unf_d    = ~sclr & (unf_q | (rdreq & empty_q));
`ifdef SHOWAHEAD_EN
        q_d      = sclr ? '0 : (usedw_d == '0) ? q_q : (remain == '0) ? data : mem[rd_ptr_d];
`else
        q_d      = sclr ? '0 : rd_ok ? mem[rd_ptr_q] : q_q;
`endif
    end

    // storage write port; contents are deliberately left untouched by reset and clear
    always_ff @(posedge clock) if (wr_ok) mem[wr_ptr_q] <= data;

    // state register; flags come from next-state occupancy so they never lag usedw
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            q_q      <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            q_q      <= q_d;
            full_q   <= usedw_d == FULL_LV;
            empty_q  <= usedw_d == '0;
            af_q     <= usedw_d >= AF_LV;
            ae_q     <= usedw_d <= AE_LV;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign q             = q_q;
    assign usedw         = usedw_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = af_q;
    assign almost_empty  = ae_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
endmodule

// File: tb/tb_indptr_fifo_p.sv
// tb_indptr_fifo_p: directed and randomized checks of indptr_fifo_p against a queue-based model.
module tb_indptr_fifo_p;
    localparam int DW = 10, DEPTH = 8, AW = 3, AF = 6, AE = 2;

    logic          clock = 0, reset_n = 1, sclr = 0, wrreq = 0, rdreq = 0;
    logic [DW-1:0] data = '0, q;
    logic [AW:0]   usedw;
    logic          full, empty, almost_full, almost_empty, overflow_err, underflow_err;

    int n_cmp = 0, n_bad = 0;
    int mq[$];
    int m_q = 0;
    bit m_ovf = 0, m_unf = 0;

    always #5 clock = ~clock;

    indptr_fifo_p #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clock(clock), .reset_n(reset_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q), .usedw(usedw), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    function automatic void model_clear();
        mq.delete();
        m_q = 0;
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic logic [19:0] exp_status();
        int n = mq.size();
        return {DW'(m_q), 4'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf};
    endfunction

    function automatic logic [19:0] dut_status();
        return {q, usedw, full, empty, almost_full, almost_empty, overflow_err, underflow_err};
    endfunction

    task automatic step(input bit w, input bit r, input int d, input bit c);
        bit rok, wok;
        int n;
        wrreq = w; rdreq = r; data = DW'(d); sclr = c;
        @(posedge clock); #1;
        if (c) model_clear();
        else begin
            n = mq.size();
            rok = r && n > 0;
            wok = w && (n < DEPTH || rok);
            if (w && n == DEPTH && !rok) m_ovf = 1;
            if (r && n == 0) m_unf = 1;
            if (rok) begin
`ifdef SHOWAHEAD_EN
                void'(mq.pop_front());
`else
                m_q = mq.pop_front();
`endif
            end
            if (wok) mq.push_back(d);
`ifdef SHOWAHEAD_EN
            if (mq.size() > 0) m_q = mq[0];
`endif
        end
        wrreq = 0; rdreq = 0; sclr = 0;
    endtask

    task automatic test_reset();
        #2 reset_n = 0;
        #1 model_clear();
        n_cmp++;
        if (dut_status() !== {10'd0, 4'd0, 6'b010100}) begin
            n_bad++; $display("FAIL reset_state: got %h expected %h", dut_status(), {10'd0, 4'd0, 6'b010100});
        end
        @(negedge clock) reset_n = 1;
    endtask

    task automatic test_basic_order();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 12 + i, 0);
            n_cmp++;
            if (usedw !== 4'(i + 1)) begin n_bad++; $display("FAIL basic_wr_usedw: got %0d expected %0d", usedw, i + 1); end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            n_cmp++;
            if (usedw !== 4'(3 - i)) begin n_bad++; $display("FAIL basic_rd_usedw: got %0d expected %0d", usedw, 3 - i); end
`ifndef SHOWAHEAD_EN
            n_cmp++;
            if (q !== DW'(12 + i)) begin n_bad++; $display("FAIL basic_rd_q: got %0d expected %0d", q, 12 + i); end
`endif
            n_cmp++;
            if (dut_status() !== exp_status()) begin n_bad++; $display("FAIL basic_status: got %h expected %h", dut_status(), exp_status()); end
        end
        n_cmp++;
        if ({empty, overflow_err, underflow_err} !== 3'b100) begin
            n_bad++; $display("FAIL basic_end_flags: got %b expected 100", {empty, overflow_err, underflow_err});
        end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < 9; i++) begin
            step(1, 0, i, 0);
            n_cmp++;
            if ({almost_full, full, usedw, overflow_err} !== {i + 1 >= AF, i + 1 >= DEPTH, 4'(i < 8 ? i + 1 : 8), i == 8}) begin
                n_bad++; $display("FAIL full_fill_%0d: got af=%b f=%b u=%0d ovf=%b", i, almost_full, full, usedw, overflow_err);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0);
            n_cmp++;
            if (dut_status() !== exp_status()) begin n_bad++; $display("FAIL full_drain: got %h expected %h", dut_status(), exp_status()); end
`ifndef SHOWAHEAD_EN
            n_cmp++;
            if (q !== DW'(i)) begin n_bad++; $display("FAIL full_drain_q: got %0d expected %0d", q, i); end
`endif
        end
    endtask

    task automatic test_full_rw();
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, i, 0);
        step(1, 1, 99, 0);
        n_cmp++;
        if ({usedw, overflow_err, full} !== {4'd8, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL full_rw: got u=%0d ovf=%b f=%b expected u=8 ovf=0 f=1", usedw, overflow_err, full);
        end
`ifndef SHOWAHEAD_EN
        n_cmp++;
        if (q !== 10'd0) begin n_bad++; $display("FAIL full_rw_q: got %0d expected 0", q); end
`endif
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        n_cmp++;
        if ({q, empty} !== {10'd99, 1'b1}) begin n_bad++; $display("FAIL full_rw_last: got q=%0d e=%b expected q=99 e=1", q, empty); end
        n_cmp++;
        if (dut_status() !== exp_status()) begin n_bad++; $display("FAIL full_rw_status: got %h expected %h", dut_status(), exp_status()); end
    endtask

    task automatic test_underflow_wrap();
        step(0, 1, 0, 0);
        n_cmp++;
        if ({underflow_err, q, usedw} !== {1'b1, 10'd99, 4'd0}) begin
            n_bad++; $display("FAIL underflow: got unf=%b q=%0d u=%0d expected unf=1 q=99 u=0", underflow_err, q, usedw);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, i > 0, 100 + i, 0);
            n_cmp++;
            if (dut_status() !== exp_status()) begin n_bad++; $display("FAIL wrap_%0d: got %h expected %h", i, dut_status(), exp_status()); end
        end
        step(0, 1, 0, 0);
        n_cmp++;
        if ({q, empty} !== {10'd119, 1'b1}) begin n_bad++; $display("FAIL wrap_last: got q=%0d e=%b expected q=119 e=1", q, empty); end
    endtask

    task automatic test_reset_clear();
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 50 + i, 0);
        step(1, 1, 7, 1);
        n_cmp++;
        if ({usedw, empty, overflow_err, underflow_err, q} !== {4'd0, 1'b1, 1'b0, 1'b0, 10'd0}) begin
            n_bad++; $display("FAIL sclr: got u=%0d e=%b ovf=%b unf=%b q=%0d", usedw, empty, overflow_err, underflow_err, q);
        end
        step(1, 0, 11, 0);
        step(1, 0, 22, 0);
        step(1, 0, 33, 0);
        step(0, 1, 0, 0);
        n_cmp++;
        if (dut_status() !== exp_status()) begin n_bad++; $display("FAIL pre_reset: got %h expected %h", dut_status(), exp_status()); end
        #2 reset_n = 0;
        #1 model_clear();
        n_cmp++;
        if ({q, usedw, empty} !== {10'd0, 4'd0, 1'b1}) begin
            n_bad++; $display("FAIL async_reset: got q=%0d u=%0d e=%b expected 0 0 1", q, usedw, empty);
        end
        #2 reset_n = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 1023)), $urandom_range(0, 49) == 0);
            n_cmp++;
            if (dut_status() !== exp_status()) begin n_bad++; $display("FAIL random_%0d: got %h expected %h", i, dut_status(), exp_status()); end
        end
    endtask

`ifdef SHOWAHEAD_EN
    task automatic test_showahead();
        step(0, 0, 0, 1);
        step(1, 0, 42, 0);
        n_cmp++;
        if ({q, empty} !== {10'd42, 1'b0}) begin n_bad++; $display("FAIL showahead_q: got q=%0d e=%b expected 42 0", q, empty); end
        step(0, 1, 0, 0);
        n_cmp++;
        if ({empty, usedw} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL showahead_pop: got e=%b u=%0d expected 1 0", empty, usedw); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_order();
        test_full_boundary();
        test_full_rw();
        test_underflow_wrap();
        test_reset_clear();
        test_random();
`ifdef SHOWAHEAD_EN
        test_showahead();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
